// File: rtl/conv3x3_pkg.sv
// Shared widths and FSM encoding for the 3x3 convolution frame sequencer.
package conv3x3_pkg;
    localparam int PIX_W  = 8;
    localparam int WIN_W  = 72;
    localparam int PSUM_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/conv3x3_linebuf.sv
// Byte delay line: o_data is the byte written DEPTH enabled shifts earlier.
module conv3x3_linebuf
    import conv3x3_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [PIX_W-1:0] i_data,
    output logic [PIX_W-1:0] o_data
);
    logic [PIX_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else if (i_en) begin
            r_mem[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) r_mem[k] <= r_mem[k-1];
        end
    end

    assign o_data = r_mem[DEPTH-1];
endmodule

// File: rtl/conv3x3_ctrl.sv
// Frame sequencer: raster pixels -> 3x3 windows for the conv core, core psums -> output stream.
module conv3x3_ctrl
    import conv3x3_pkg::*;
#(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int CORE_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [WIN_W-1:0]  i_filter,
    input  logic              i_pix_valid,
    output logic              o_pix_ready,
    input  logic [PIX_W-1:0]  i_pix_data,
    output logic              o_core_state,
    output logic [WIN_W-1:0]  o_core_ifmap,
    output logic [WIN_W-1:0]  o_core_filter,
    input  logic [PSUM_W-1:0] i_core_psum,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [PSUM_W-1:0] o_out_data,
    output logic              o_busy,
    output logic              o_done,
    output state_t            o_dbg_state
);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int DEPTH = CORE_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int FLW   = $clog2(2 * CORE_LAT + 4);
    localparam int NWIN  = (IMG_H - 2) * (IMG_W - 2);
    localparam int OW    = $clog2(NWIN + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(NWIN - 1);

    state_t              r_state, w_next_state;
    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic                r_first, r_core_state, r_done;
    logic [WIN_W-1:0]    r_filter, r_ifmap, w_window;
    logic [PIX_W-1:0]    r_c0 [3];
    logic [PIX_W-1:0]    r_c1 [3];
    logic [PIX_W-1:0]    w_col [3];
    logic [PIX_W-1:0]    w_lb1, w_lb2;
    logic [CORE_LAT:0]   r_vld_sr;
    logic [PSUM_W-1:0]   r_fifo [DEPTH];
    logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [CNTW-1:0]     r_count;
    logic [OW-1:0]       r_out_cnt;
    logic [FLW-1:0]      w_inflight, w_fill;
    logic                w_pix_ready, w_pix_fire, w_out_fire, w_last_pix, w_last_out;
    logic                w_win_fire, w_fifo_wr, w_start_ok;

    assign w_pix_fire = i_pix_valid && w_pix_ready;
    assign w_out_fire = o_out_valid && i_out_ready;
    assign w_last_pix = (r_col == COL_LAST) && (r_row == ROW_LAST);
    assign w_last_out = w_out_fire && (r_out_cnt == OUT_LAST);
    assign w_win_fire = w_pix_fire && (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_fifo_wr  = r_vld_sr[CORE_LAT];
    assign w_start_ok = (r_state == ST_IDLE) && i_start;

    conv3x3_linebuf #(.DEPTH(IMG_W)) u_lb1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_pix_fire), .i_data(i_pix_data), .o_data(w_lb1)
    );
    conv3x3_linebuf #(.DEPTH(IMG_W)) u_lb2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_pix_fire), .i_data(w_lb1), .o_data(w_lb2)
    );

    // Incoming column, oldest row first; with the two held columns it forms the window.
    always_comb begin
        w_col[0] = w_lb2;
        w_col[1] = w_lb1;
        w_col[2] = i_pix_data;
        w_window = '0;
        for (int i = 0; i < 3; i++) begin
            w_window[8*(3*i+0) +: 8] = r_c0[i];
            w_window[8*(3*i+1) +: 8] = r_c1[i];
            w_window[8*(3*i+2) +: 8] = w_col[i];
        end
    end

    // Windows already launched but not yet in the FIFO still claim a slot.
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k <= CORE_LAT; k++) w_inflight = w_inflight + FLW'(r_vld_sr[k]);
        w_fill = FLW'(r_count) + w_inflight;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next_state = ST_RUN;
            ST_RUN:   if (w_pix_fire && w_last_pix) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_last_out) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pix_ready = (r_state == ST_RUN) && (w_fill <= FLW'(CORE_LAT));
        o_busy      = (r_state != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_first      <= 1'b0;
            r_filter     <= '0;
            r_ifmap      <= '0;
            r_core_state <= 1'b0;
            r_vld_sr     <= '0;
            r_out_cnt    <= '0;
            r_done       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_c0[i] <= '0;
                r_c1[i] <= '0;
            end
        end else begin
            if (w_start_ok) begin
                r_filter  <= i_filter;
                r_col     <= '0;
                r_row     <= '0;
                r_out_cnt <= '0;
                r_first   <= 1'b1;
            end
            if (w_pix_fire) begin
                for (int i = 0; i < 3; i++) begin
                    r_c0[i] <= r_c1[i];
                    r_c1[i] <= w_col[i];
                end
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            if (w_win_fire) begin
                r_ifmap <= w_window;
                r_first <= 1'b0;
            end
            r_core_state <= w_win_fire && r_first;
            r_vld_sr     <= {r_vld_sr[CORE_LAT-1:0], w_win_fire};
            if (w_out_fire) r_out_cnt <= w_last_out ? '0 : r_out_cnt + OW'(1);
            r_done <= (r_state == ST_DRAIN) && w_last_out;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) r_fifo[k] <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_fifo[r_wr_ptr] <= i_core_psum;
                r_wr_ptr         <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_out_fire) r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
            case ({w_fifo_wr, w_out_fire})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pix_ready   = w_pix_ready;
    assign o_core_state  = r_core_state;
    assign o_core_ifmap  = r_ifmap;
    assign o_core_filter = r_filter;
    assign o_out_valid   = (r_count != '0);
    assign o_out_data    = r_fifo[r_rd_ptr];
    assign o_done        = r_done;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_conv3x3_ctrl.sv
// Self-checking bench for conv3x3_ctrl: 4x4 frame vectors, corner sequences, random 8x8 frame.
module tb_conv3x3_ctrl;
    import conv3x3_pkg::*;

    typedef struct {
        logic [71:0]       filter;
        int                stall;
        int                mid_start;
        logic [3:0][15:0]  exp_out;
    } vec_t;

    localparam logic [71:0] FIRST_WIN = 72'h0A0908060504020100;
    localparam logic [71:0] ONES_FLT  = 72'h010101010101010101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- 4x4 instance ----------------
    logic        rst4 = 1'b1, start4 = 1'b0, pix_valid4 = 1'b0, out_ready4 = 1'b1;
    logic [71:0] filter4 = '0;
    logic [7:0]  pix_data4 = '0;
    logic        pix_ready4, core_state4, out_valid4, busy4, done4;
    logic [71:0] core_ifmap4, core_filter4;
    logic [15:0] core_psum4 = '0, out_data4;
    state_t      dbg_state4;

    conv3x3_ctrl #(.IMG_W(4), .IMG_H(4), .CORE_LAT(1)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_start(start4), .i_filter(filter4),
        .i_pix_valid(pix_valid4), .o_pix_ready(pix_ready4), .i_pix_data(pix_data4),
        .o_core_state(core_state4), .o_core_ifmap(core_ifmap4), .o_core_filter(core_filter4),
        .i_core_psum(core_psum4), .o_out_valid(out_valid4), .i_out_ready(out_ready4),
        .o_out_data(out_data4), .o_busy(busy4), .o_done(done4), .o_dbg_state(dbg_state4)
    );

    // ---------------- 8x8 instance ----------------
    logic        rst8 = 1'b1, start8 = 1'b0, pix_valid8 = 1'b0, out_ready8 = 1'b1;
    logic [71:0] filter8 = '0;
    logic [7:0]  pix_data8 = '0;
    logic        pix_ready8, core_state8, out_valid8, busy8, done8;
    logic [71:0] core_ifmap8, core_filter8;
    logic [15:0] core_psum8 = '0, out_data8;
    state_t      dbg_state8;

    conv3x3_ctrl #(.IMG_W(8), .IMG_H(8), .CORE_LAT(1)) dut8 (
        .i_clk(clk), .i_rst(rst8), .i_start(start8), .i_filter(filter8),
        .i_pix_valid(pix_valid8), .o_pix_ready(pix_ready8), .i_pix_data(pix_data8),
        .o_core_state(core_state8), .o_core_ifmap(core_ifmap8), .o_core_filter(core_filter8),
        .i_core_psum(core_psum8), .o_out_valid(out_valid8), .i_out_ready(out_ready8),
        .o_out_data(out_data8), .o_busy(busy8), .o_done(done8), .o_dbg_state(dbg_state8)
    );

    // Behavioural conv core, one cycle of latency.
    function automatic logic [15:0] dot9(input logic [71:0] a, input logic [71:0] f);
        logic [15:0] s;
        s = '0;
        for (int k = 0; k < 9; k++) s = s + 16'(a[8*k +: 8]) * 16'(f[8*k +: 8]);
        return s;
    endfunction

    always @(posedge clk) begin
        core_psum4 <= dot9(core_ifmap4, core_filter4);
        core_psum8 <= dot9(core_ifmap8, core_filter8);
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [15:0] exp_q[$];
    logic [15:0] exp8_q[$];
    int          frame_outs = 0, done_cnt = 0, out_at_done = 0, state_hi_cnt = 0;
    int          outs8 = 0, done8_cnt = 0;
    logic [71:0] state_ifmap = '0;
    logic        stall_on = 1'b0, saw_drop = 1'b0;

    always @(negedge clk) begin
        if (!rst4) begin
            if (out_valid4 && out_ready4) begin
                frame_outs++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out4_extra: actual %0h required none", out_data4);
                end else begin
                    check("out4_data", 72'(out_data4), 72'(exp_q.pop_front()));
                end
            end
            if (done4) begin
                done_cnt++;
                out_at_done = frame_outs;
            end
            if (core_state4) begin
                state_hi_cnt++;
                state_ifmap = core_ifmap4;
            end
            if (stall_on && busy4 && !pix_ready4) saw_drop = 1'b1;
        end
        if (!rst8) begin
            if (out_valid8 && out_ready8) begin
                outs8++;
                if (exp8_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out8_extra: actual %0h required none", out_data8);
                end else begin
                    check("out8_data", 72'(out_data8), 72'(exp8_q.pop_front()));
                end
            end
            if (done8) done8_cnt++;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_pix4(input logic [7:0] d);
        int   t;
        logic hs;
        t = 0;
        hs = 1'b0;
        pix_valid4 = 1'b1;
        pix_data4  = d;
        while (!hs && t < 200) begin
            @(negedge clk);
            hs = pix_ready4;
            @(posedge clk);
            #1;
            t++;
        end
        pix_valid4 = 1'b0;
        check("pix4_accept", 72'(hs), 72'(1));
    endtask

    task automatic send_pix8(input logic [7:0] d);
        int   t;
        logic hs;
        t = 0;
        hs = 1'b0;
        pix_valid8 = 1'b1;
        pix_data8  = d;
        while (!hs && t < 200) begin
            @(negedge clk);
            hs = pix_ready8;
            @(posedge clk);
            #1;
            t++;
        end
        pix_valid8 = 1'b0;
        check("pix8_accept", 72'(hs), 72'(1));
    endtask

    task automatic pulse_start4(input logic [71:0] f);
        @(posedge clk); #1;
        start4  = 1'b1;
        filter4 = f;
        @(posedge clk); #1;
        start4  = 1'b0;
    endtask

    task automatic check_reset4(input string tag);
        @(negedge clk);
        check({tag, "_state"},  72'(dbg_state4), 72'(ST_IDLE));
        check({tag, "_busy"},   72'(busy4), 72'(0));
        check({tag, "_oval"},   72'(out_valid4), 72'(0));
        check({tag, "_pready"}, 72'(pix_ready4), 72'(0));
        check({tag, "_done"},   72'(done4), 72'(0));
        check({tag, "_cstate"}, 72'(core_state4), 72'(0));
        check({tag, "_ifmap"},  core_ifmap4, 72'(0));
        check({tag, "_cfilt"},  core_filter4, 72'(0));
        check({tag, "_odata"},  72'(out_data4), 72'(0));
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int t;
        for (int k = 0; k < 4; k++) exp_q.push_back(v.exp_out[k]);
        frame_outs = 0;
        done_cnt = 0;
        state_hi_cnt = 0;
        saw_drop = 1'b0;
        out_ready4 = 1'b1;
        pulse_start4(v.filter);
        fork
            begin
                for (int p = 0; p < 16; p++) begin
                    if (v.mid_start != 0 && p == 5) begin
                        start4  = 1'b1;
                        filter4 = ~v.filter;
                    end
                    send_pix4(8'(p));
                    start4  = 1'b0;
                    filter4 = v.filter;
                end
            end
            begin
                if (v.stall > 0) begin
                    int w;
                    w = 0;
                    while (frame_outs < 1 && w < 500) begin
                        @(posedge clk);
                        w++;
                    end
                    #1;
                    out_ready4 = 1'b0;
                    stall_on = 1'b1;
                    repeat (v.stall) @(posedge clk);
                    #1;
                    out_ready4 = 1'b1;
                    stall_on = 1'b0;
                end
            end
        join
        t = 0;
        while (done_cnt == 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_outs"},      72'(frame_outs), 72'(4));
        check({tag, "_left"},      72'(exp_q.size()), 72'(0));
        check({tag, "_done_cnt"},  72'(done_cnt), 72'(1));
        check({tag, "_done_pos"},  72'(out_at_done), 72'(4));
        check({tag, "_state_cnt"}, 72'(state_hi_cnt), 72'(1));
        check({tag, "_state_win"}, state_ifmap, FIRST_WIN);
        check({tag, "_filter"},    core_filter4, v.filter);
        check({tag, "_busy"},      72'(busy4), 72'(0));
        if (v.stall > 0) check({tag, "_ready_drop"}, 72'(saw_drop), 72'(1));
        exp_q.delete();
    endtask

    task automatic reset_mid_frame(input int n_pix, input string tag);
        out_ready4 = 1'b0;
        pulse_start4(ONES_FLT);
        for (int p = 0; p < n_pix; p++) send_pix4(8'(p));
        repeat (4) @(posedge clk);
        @(negedge clk);
        if (n_pix >= 12) check({tag, "_pre_oval"}, 72'(out_valid4), 72'(1));
        check({tag, "_pre_busy"}, 72'(busy4), 72'(1));
        @(posedge clk); #1;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        out_ready4 = 1'b1;
        check_reset4(tag);
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[5];

    initial begin
        vecs[0].filter = 72'h010000000100000001; vecs[0].stall = 0;  vecs[0].mid_start = 0;
        vecs[0].exp_out = {16'h001E, 16'h001B, 16'h0012, 16'h000F};
        vecs[1].filter = 72'h010000000100000001; vecs[1].stall = 20; vecs[1].mid_start = 0;
        vecs[1].exp_out = {16'h001E, 16'h001B, 16'h0012, 16'h000F};
        vecs[2].filter = ONES_FLT;               vecs[2].stall = 0;  vecs[2].mid_start = 0;
        vecs[2].exp_out = {16'h005A, 16'h0051, 16'h0036, 16'h002D};
        vecs[3].filter = 72'h000000000200000000; vecs[3].stall = 0;  vecs[3].mid_start = 1;
        vecs[3].exp_out = {16'h0014, 16'h0012, 16'h000C, 16'h000A};
        vecs[4].filter = 72'hFF00000000000000FF; vecs[4].stall = 5;  vecs[4].mid_start = 0;
        vecs[4].exp_out = {16'h13EC, 16'h11EE, 16'h0BF4, 16'h09F6};

        repeat (3) @(posedge clk);
        #1;
        rst4 = 1'b0;
        rst8 = 1'b0;
        check_reset4("por");
        check("por8_state", 72'(dbg_state8), 72'(ST_IDLE));
        check("por8_oval",  72'(out_valid8), 72'(0));

        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        reset_mid_frame(10, "rst10");
        run_frame(vecs[0], "after_rst10");
        reset_mid_frame(12, "rst12");
        run_frame(vecs[2], "after_rst12");

        // 8x8 all-ones frame with random input gaps and output backpressure.
        for (int k = 0; k < 36; k++) exp8_q.push_back(16'h0009);
        @(posedge clk); #1;
        start8  = 1'b1;
        filter8 = ONES_FLT;
        @(posedge clk); #1;
        start8  = 1'b0;
        fork
            begin
                for (int p = 0; p < 64; p++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pix_valid8 = 1'b0;
                        @(posedge clk); #1;
                    end
                    send_pix8(8'h01);
                end
            end
            begin
                int w;
                w = 0;
                while (done8_cnt == 0 && w < 3000) begin
                    out_ready8 = ($urandom_range(0, 1) == 1);
                    @(posedge clk); #1;
                    w++;
                end
                out_ready8 = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("rand8_outs",     72'(outs8), 72'(36));
        check("rand8_left",     72'(exp8_q.size()), 72'(0));
        check("rand8_done_cnt", 72'(done8_cnt), 72'(1));
        check("rand8_busy",     72'(busy8), 72'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
